// File: rtl/fir_mac_pipe_if.sv
// Sample/coefficient stream into the FIR multiplier and the product/sum stream out of it.
// The master drives beats and the clock enable; the slave (fir_mac_pipe) returns results.
interface fir_mac_pipe_if #(
   parameter int din0_WIDTH = 32,
   parameter int din1_WIDTH = 10,
   parameter int dout_WIDTH = 32
);

   logic                  ce;
   logic                  in_valid;
   logic                  in_last;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic                  out_valid;
   logic [dout_WIDTH-1:0] dout;

   modport master (
      output ce,
      output in_valid,
      output in_last,
      output din0,
      output din1,
      input  out_valid,
      input  dout
   );

   modport slave (
      input  ce,
      input  in_valid,
      input  in_last,
      input  din0,
      input  din1,
      output out_valid,
      output dout
   );

endinterface

// File: rtl/fir_mac_pipe.sv
// Pipelined signed x (un)signed multiplier for FIR taps, optionally accumulating tap products
// into a sum that is emitted (truncated or saturated) on the beat marked in_last.
module fir_mac_pipe #(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 2,
   parameter int din0_WIDTH  = 32,
   parameter int din1_WIDTH  = 10,
   parameter int DIN1_SIGNED = 0,
   parameter int ACC_WIDTH   = 48,
   parameter int dout_WIDTH  = 32,
   parameter int MODE        = 1,
   parameter int SATURATE    = 0
) (
   input logic           clk,
   input logic           reset,
   fir_mac_pipe_if.slave bus
);

   // In MODE 0 the output register is the last of the NUM_STAGE stages; in MODE 1 the
   // accumulator/output register sits behind all NUM_STAGE product stages.
   localparam int DEPTH = (MODE == 1) ? NUM_STAGE : NUM_STAGE - 1;

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH-1:0] din0Ext;
   logic signed [ACC_WIDTH-1:0] din1Ext;
   logic signed [ACC_WIDTH-1:0] prod;

   logic signed [ACC_WIDTH-1:0] tailP;
   logic                        tailV;
   logic                        tailL;

   logic signed [ACC_WIDTH-1:0] sum;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic                        first_q;
   logic                        first_d;
   logic [dout_WIDTH-1:0]       dout_q;
   logic [dout_WIDTH-1:0]       dout_d;
   logic                        outValid_q;
   logic                        outValid_d;

   assign din0Ext = ACC_WIDTH'($signed(bus.din0));

   generate
      if (DIN1_SIGNED != 0) begin : gDin1Signed
         assign din1Ext = ACC_WIDTH'($signed(bus.din1));
      end else begin : gDin1Unsigned
         assign din1Ext = ACC_WIDTH'(bus.din1);
      end
   endgenerate

   // The true product always fits in ACC_WIDTH, so a modulo-2^ACC_WIDTH multiply is exact.
   assign prod = din0Ext * din1Ext;

   generate
      if (DEPTH == 0) begin : gNoPipe
         assign tailP = prod;
         assign tailV = bus.in_valid;
         assign tailL = bus.in_valid & bus.in_last;
      end else begin : gPipe
         logic signed [ACC_WIDTH-1:0] prod_q [DEPTH];
         logic [DEPTH-1:0]            valid_q;
         logic [DEPTH-1:0]            last_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  prod_q[i] <= '0;
               end
               valid_q <= '0;
               last_q  <= '0;
            end else if (bus.ce) begin
               prod_q[0]  <= prod;
               valid_q[0] <= bus.in_valid;
               last_q[0]  <= bus.in_valid & bus.in_last;
               for (int i = 1; i < DEPTH; i++) begin
                  prod_q[i]  <= prod_q[i-1];
                  valid_q[i] <= valid_q[i-1];
                  last_q[i]  <= last_q[i-1];
               end
            end
         end

         assign tailP = prod_q[DEPTH-1];
         assign tailV = valid_q[DEPTH-1];
         assign tailL = last_q[DEPTH-1];
      end
   endgenerate

   function automatic logic [dout_WIDTH-1:0] fmt(input logic signed [ACC_WIDTH-1:0] x);
      logic signed [ACC_WIDTH-1:0] y;
      y = x;
      if (SATURATE != 0) begin
         if (x > SAT_MAX) begin
            y = SAT_MAX;
         end else if (x < SAT_MIN) begin
            y = SAT_MIN;
         end
      end
      return y[dout_WIDTH-1:0];
   endfunction

   // A sum whose first beat is at the tail ignores whatever the accumulator still holds.
   always_comb begin
      sum        = (first_q ? '0 : acc_q) + tailP;
      acc_d      = acc_q;
      first_d    = first_q;
      dout_d     = dout_q;
      outValid_d = 1'b0;
      if (MODE == 1) begin
         if (tailV) begin
            if (tailL) begin
               dout_d     = fmt(sum);
               outValid_d = 1'b1;
               acc_d      = '0;
               first_d    = 1'b1;
            end else begin
               acc_d   = sum;
               first_d = 1'b0;
            end
         end
      end else begin
         if (tailV) begin
            dout_d     = fmt(tailP);
            outValid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q      <= '0;
         first_q    <= 1'b1;
         dout_q     <= '0;
         outValid_q <= 1'b0;
      end else if (bus.ce) begin
         acc_q      <= acc_d;
         first_q    <= first_d;
         dout_q     <= dout_d;
         outValid_q <= outValid_d;
      end
   end

   assign bus.out_valid = outValid_q;
   assign bus.dout      = dout_q;

endmodule

// File: tb/tb_fir_mac_pipe.sv
// Directed bench: four fir_mac_pipe variants (plain unsigned/signed multiply, accumulate with
// truncation and with saturation) share one stimulus stream; each check targets the relevant one.
module tb_fir_mac_pipe;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        inValid;
   logic        inLast;
   logic [31:0] din0;
   logic [9:0]  din1;

   int testsRun;
   int testsFailed;

   fir_mac_pipe_if #(.din0_WIDTH(32), .din1_WIDTH(10), .dout_WIDTH(32)) ifU ();
   fir_mac_pipe_if #(.din0_WIDTH(32), .din1_WIDTH(10), .dout_WIDTH(32)) ifS ();
   fir_mac_pipe_if #(.din0_WIDTH(32), .din1_WIDTH(10), .dout_WIDTH(32)) ifA ();
   fir_mac_pipe_if #(.din0_WIDTH(32), .din1_WIDTH(10), .dout_WIDTH(32)) ifT ();

   assign ifU.ce = ce;  assign ifU.in_valid = inValid;  assign ifU.in_last = inLast;
   assign ifU.din0 = din0;  assign ifU.din1 = din1;
   assign ifS.ce = ce;  assign ifS.in_valid = inValid;  assign ifS.in_last = inLast;
   assign ifS.din0 = din0;  assign ifS.din1 = din1;
   assign ifA.ce = ce;  assign ifA.in_valid = inValid;  assign ifA.in_last = inLast;
   assign ifA.din0 = din0;  assign ifA.din1 = din1;
   assign ifT.ce = ce;  assign ifT.in_valid = inValid;  assign ifT.in_last = inLast;
   assign ifT.din0 = din0;  assign ifT.din1 = din1;

   fir_mac_pipe #(.NUM_STAGE(2), .DIN1_SIGNED(0), .MODE(0), .SATURATE(0))
      uMulU (.clk(clk), .reset(reset), .bus(ifU));
   fir_mac_pipe #(.NUM_STAGE(2), .DIN1_SIGNED(1), .MODE(0), .SATURATE(0))
      uMulS (.clk(clk), .reset(reset), .bus(ifS));
   fir_mac_pipe #(.NUM_STAGE(2), .DIN1_SIGNED(0), .MODE(1), .SATURATE(0))
      uMacTrunc (.clk(clk), .reset(reset), .bus(ifA));
   fir_mac_pipe #(.NUM_STAGE(2), .DIN1_SIGNED(0), .MODE(1), .SATURATE(1))
      uMacSat (.clk(clk), .reset(reset), .bus(ifT));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge, so outputs read on return reflect that edge.
   task automatic applyStimulus(input logic v, input logic l, input logic [31:0] a,
                                input logic [9:0] b);
      inValid = v;
      inLast  = l;
      din0    = a;
      din1    = b;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset   = 1'b1;
      ce      = 1'b1;
      inValid = 1'b0;
      inLast  = 1'b0;
      din0    = '0;
      din1    = '0;

      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("rst_ovalid", ifA.out_valid, 1'b0);
      checkOutput("rst_dout", ifA.dout, 32'd0);
      checkOutput("rst_dout_mul", ifU.dout, 32'd0);
      reset = 1'b0;

      // Plain multiply: -3 * 1000, then 2 * 0x3FF (1023 unsigned, -1 signed)
      applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFD, 10'd1000);
      checkOutput("mul_lat1_ovalid", ifU.out_valid, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'd2, 10'h3FF);
      checkOutput("mul_lat2_ovalid", ifU.out_valid, 1'b1);
      checkOutput("mul_neg3x1000", ifU.dout, 32'hFFFF_F448);
      checkOutput("muls_neg3xneg24", ifS.dout, 32'd72);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("mul_2x1023", ifU.dout, 32'd2046);
      checkOutput("muls_2xneg1", ifS.dout, 32'hFFFF_FFFE);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("mul_bubble_ovalid", ifU.out_valid, 1'b0);
      checkOutput("mul_bubble_hold", ifU.dout, 32'd2046);

      applyStimulus(1'b1, 1'b0, 32'd5, 10'h3FF);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("muls_5xneg1", ifS.dout, 32'hFFFF_FFFB);
      checkOutput("muls_ovalid", ifS.out_valid, 1'b1);
      checkOutput("mul_5x1023", ifU.dout, 32'd5115);

      // Clear the accumulators of the partial sums fed by the multiply vectors
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      reset = 1'b0;

      // Back-to-back sums: 1*2+3*4+5*6 = 44, then the single-beat sum 7*1
      applyStimulus(1'b1, 1'b0, 32'd1, 10'd2);
      applyStimulus(1'b1, 1'b0, 32'd3, 10'd4);
      applyStimulus(1'b1, 1'b1, 32'd5, 10'd6);
      checkOutput("mac_early_ovalid_a", ifA.out_valid, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'd7, 10'd1);
      checkOutput("mac_early_ovalid_b", ifA.out_valid, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("mac_sum44_ovalid", ifA.out_valid, 1'b1);
      checkOutput("mac_sum44", ifA.dout, 32'd44);
      checkOutput("macsat_sum44", ifT.dout, 32'd44);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("mac_sum7_ovalid", ifA.out_valid, 1'b1);
      checkOutput("mac_sum7", ifA.dout, 32'd7);
      checkOutput("macsat_sum7", ifT.dout, 32'd7);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("mac_idle_ovalid", ifA.out_valid, 1'b0);
      checkOutput("mac_idle_hold", ifA.dout, 32'd7);

      // Clock-enable stall in the middle of a sum; beats offered while stalled are not taken
      applyStimulus(1'b1, 1'b0, 32'd1, 10'd2);
      applyStimulus(1'b1, 1'b0, 32'd3, 10'd4);
      ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 32'd9, 10'd9);
         checkOutput("stall_mac_ovalid", ifA.out_valid, 1'b0);
         checkOutput("stall_mul_hold", ifU.dout, 32'd2);
         checkOutput("stall_mul_ovalid", ifU.out_valid, 1'b1);
      end
      ce = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'd5, 10'd6);
      checkOutput("stall_mul_resume", ifU.dout, 32'd12);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("stall_mac_pending", ifA.out_valid, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("stall_sum44_ovalid", ifA.out_valid, 1'b1);
      checkOutput("stall_sum44", ifA.dout, 32'd44);
      ce = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("stall_ovalid_held", ifA.out_valid, 1'b1);
      checkOutput("stall_dout_held", ifA.dout, 32'd44);
      ce = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("stall_ovalid_once", ifA.out_valid, 1'b0);

      // 2^30*3 + 2^30*3 = 6*2^30 overflows 32 bits
      applyStimulus(1'b1, 1'b0, 32'h4000_0000, 10'd3);
      applyStimulus(1'b1, 1'b1, 32'h4000_0000, 10'd3);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("sat_pos", ifT.dout, 32'h7FFF_FFFF);
      checkOutput("trunc_pos", ifA.dout, 32'h8000_0000);
      checkOutput("sat_pos_ovalid", ifT.out_valid, 1'b1);

      // -2^30*2 + -2^30*3 = -5*2^30 underflows 32 bits
      applyStimulus(1'b1, 1'b0, 32'hC000_0000, 10'd2);
      applyStimulus(1'b1, 1'b1, 32'hC000_0000, 10'd3);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("sat_neg", ifT.dout, 32'h8000_0000);
      checkOutput("trunc_neg", ifA.dout, 32'hC000_0000);

      // Reset mid-sequence, asserted while ce is low, must still clear everything
      applyStimulus(1'b1, 1'b0, 32'd100, 10'd100);
      applyStimulus(1'b1, 1'b0, 32'd100, 10'd100);
      reset = 1'b1;
      ce    = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("rst_mid_ovalid", ifA.out_valid, 1'b0);
      checkOutput("rst_mid_dout", ifA.dout, 32'd0);
      checkOutput("rst_mid_mul_dout", ifU.dout, 32'd0);
      ce = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("post_rst_ovalid", ifA.out_valid, 1'b0);
      checkOutput("post_rst_dout", ifA.dout, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'd9, 10'd9);
      applyStimulus(1'b1, 1'b1, 32'd2, 10'd3);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("post_rst_pending", ifA.out_valid, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 10'd0);
      checkOutput("post_rst_sum6_ovalid", ifA.out_valid, 1'b1);
      checkOutput("post_rst_sum6", ifA.dout, 32'd6);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
